// File: rtl/mux_n_para_1_reg_pkg.sv
// Shared definitions for the registered N:1 multiplexer: operating modes,
// output register states and the select-width helper.
package mux_n_para_1_reg_pkg;

  localparam int MUX_MODO_FIXO = 0;
  localparam int MUX_MODO_RR   = 1;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Select width never drops below one bit, even for a degenerate channel count.
  function automatic int sel_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_para_1_reg_if.sv
// Channel-side and consumer-side handshake bundle of mux_n_para_1_reg.
interface mux_n_para_1_reg_if
  import mux_n_para_1_reg_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CANAIS  = 4
);
  localparam int SEL_W = sel_w(unsigned'(CANAIS));

  logic [CANAIS*LARGURA-1:0] D;
  logic [CANAIS-1:0]         D_valid;
  logic [CANAIS-1:0]         D_ready;
  logic [SEL_W-1:0]          S;
  logic [LARGURA-1:0]        Y;
  logic                      Y_valid;
  logic                      Y_ready;
  logic [SEL_W-1:0]          Y_canal;

  modport master (
    output D, D_valid, S, Y_ready,
    input  D_ready, Y, Y_valid, Y_canal
  );

  modport slave (
    input  D, D_valid, S, Y_ready,
    output D_ready, Y, Y_valid, Y_canal
  );

endinterface

// File: rtl/mux_n_para_1_reg_arbitro.sv
// Stateless round-robin arbiter: grants the first requester at or after ptr,
// wrapping to the lowest requester when nothing lies above ptr.
module arbitro_round_robin
  import mux_n_para_1_reg_pkg::*;
#(
  parameter int CANAIS = 4
) (
  input  logic [CANAIS-1:0]                      req,
  input  logic [sel_w(unsigned'(CANAIS))-1:0]    ptr,
  output logic [CANAIS-1:0]                      grant,
  output logic [sel_w(unsigned'(CANAIS))-1:0]    idx
);
  localparam int SEL_W = sel_w(unsigned'(CANAIS));

  logic [CANAIS-1:0] mascara;
  logic [CANAIS-1:0] alto;
  logic [CANAIS-1:0] alvo;

  // Requests at or above ptr take precedence; otherwise the search wraps to bit 0.
  always_comb begin
    for (int unsigned i = 0; i < CANAIS; i++) begin
      mascara[i] = (i >= 32'(ptr));
    end
    alto  = req & mascara;
    alvo  = (|alto) ? alto : req;
    grant = alvo & (~alvo + CANAIS'(1));
  end

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < CANAIS; i++) begin
      if (grant[i]) idx = idx | SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux_n_para_1_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready on every channel;
// selection is either the external S input or round-robin arbitration.
module mux_n_para_1_reg
  import mux_n_para_1_reg_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CANAIS  = 4,
  parameter int MODO    = MUX_MODO_FIXO
) (
  input logic               clk,
  input logic               rst_n,
  mux_n_para_1_reg_if.slave bus
);
  localparam int SEL_W = sel_w(unsigned'(CANAIS));

  estado_t             estado;
  logic [SEL_W-1:0]    ptr;
  logic                livre;
  logic                carga;
  logic [CANAIS-1:0]   grant;
  logic [CANAIS-1:0]   rr_grant;
  logic [SEL_W-1:0]    idx;
  logic [SEL_W-1:0]    rr_idx;
  logic [LARGURA-1:0]  dado;

  arbitro_round_robin #(
    .CANAIS(CANAIS)
  ) u_arbitro (
    .req   (bus.D_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_comb begin
    grant = '0;
    idx   = '0;
    if (MODO == MUX_MODO_RR) begin
      grant = rr_grant;
      idx   = rr_idx;
    end else if (32'(bus.S) < CANAIS) begin
      grant[bus.S] = bus.D_valid[bus.S];
      idx          = bus.S;
    end
  end

  assign livre       = (estado == VAZIO) | bus.Y_ready;
  assign bus.D_ready = grant & {CANAIS{livre & rst_n}};
  assign carga       = |bus.D_ready;

  always_comb begin
    dado = '0;
    for (int unsigned i = 0; i < CANAIS; i++) begin
      dado = dado | (bus.D[i*LARGURA +: LARGURA] & {LARGURA{grant[i]}});
    end
  end

  // A load takes priority over a plain consume, so back-to-back words leave no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= VAZIO;
      bus.Y       <= '0;
      bus.Y_canal <= '0;
      ptr         <= '0;
    end else if (carga) begin
      estado      <= CHEIO;
      bus.Y       <= dado;
      bus.Y_canal <= idx;
      if (MODO == MUX_MODO_RR) begin
        ptr <= (idx == SEL_W'(CANAIS - 1)) ? '0 : idx + SEL_W'(1);
      end
    end else if (bus.Y_ready) begin
      estado <= VAZIO;
    end
  end

  assign bus.Y_valid = (estado == CHEIO);

endmodule

// File: tb/tb_mux_n_para_1_reg.sv
// Scoreboard bench for mux_n_para_1_reg: a fixed-select instance (5 channels,
// so S can exceed the channel count) and a round-robin instance (4 channels).
module tb_mux_n_para_1_reg;
  import mux_n_para_1_reg_pkg::*;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  exp_t q_f[$];
  exp_t q_r[$];
  bit   m_full_f = 1'b0;
  bit   m_full_r = 1'b0;
  int   m_ptr_r = 0;

  always #5 clk = ~clk;

  mux_n_para_1_reg_if #(.LARGURA(8), .CANAIS(5)) bf ();
  mux_n_para_1_reg_if #(.LARGURA(8), .CANAIS(4)) br ();

  mux_n_para_1_reg #(.LARGURA(8), .CANAIS(5), .MODO(MUX_MODO_FIXO)) u_fixo (
    .clk(clk), .rst_n(rst_n), .bus(bf)
  );
  mux_n_para_1_reg #(.LARGURA(8), .CANAIS(4), .MODO(MUX_MODO_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(br)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference arbitration: returns the granted channel, or -1 for none.
  function automatic int grant_ref(input int c, input bit rr, input logic [7:0] v,
                                   input int s, input int p);
    if (!rr) return (s < c && v[s]) ? s : -1;
    for (int k = 0; k < c; k++) begin
      if (v[(p + k) % c]) return (p + k) % c;
    end
    return -1;
  endfunction

  // One clock cycle: check combinational handshake against the model, then
  // advance the model across the rising edge. Called at a falling edge.
  task automatic step();
    int gf;
    int gr;
    logic [4:0] ef;
    logic [3:0] er;
    #1;
    ef = '0;
    er = '0;
    gf = -1;
    gr = -1;
    if (rst_n) begin
      gf = grant_ref(5, 1'b0, 8'(bf.D_valid), int'(bf.S), 0);
      gr = grant_ref(4, 1'b1, 8'(br.D_valid), 0, m_ptr_r);
      if (gf >= 0 && (!m_full_f || bf.Y_ready)) ef[gf] = 1'b1;
      if (gr >= 0 && (!m_full_r || br.Y_ready)) er[gr] = 1'b1;
    end
    chk("d_ready_fixo", 64'(bf.D_ready), 64'(ef));
    chk("d_ready_rr", 64'(br.D_ready), 64'(er));
    chk("y_valid_fixo", 64'(bf.Y_valid), 64'(m_full_f));
    chk("y_valid_rr", 64'(br.Y_valid), 64'(m_full_r));
    @(posedge clk);
    if (!rst_n) begin
      m_full_f = 1'b0;
      m_full_r = 1'b0;
      m_ptr_r  = 0;
      q_f.delete();
      q_r.delete();
    end else begin
      if (ef != '0) begin
        q_f.push_back('{d: bf.D[gf*8 +: 8], c: gf});
        m_full_f = 1'b1;
      end else if (bf.Y_ready) begin
        m_full_f = 1'b0;
      end
      if (er != '0) begin
        q_r.push_back('{d: br.D[gr*8 +: 8], c: gr});
        m_full_r = 1'b1;
        m_ptr_r  = (gr + 1) % 4;
      end else if (br.Y_ready) begin
        m_full_r = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && bf.Y_valid) begin
      compared++;
      if (q_f.size() == 0) begin
        mismatched++;
        $display("FAIL sb_fixo: Y_valid=1 Y=%0h but no word expected", bf.Y);
      end else begin
        chk("sb_fixo_y", 64'(bf.Y), 64'(q_f[0].d));
        chk("sb_fixo_canal", 64'(bf.Y_canal), 64'(q_f[0].c));
        if (bf.Y_ready) void'(q_f.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && br.Y_valid) begin
      compared++;
      if (q_r.size() == 0) begin
        mismatched++;
        $display("FAIL sb_rr: Y_valid=1 Y=%0h but no word expected", br.Y);
      end else begin
        chk("sb_rr_y", 64'(br.Y), 64'(q_r[0].d));
        chk("sb_rr_canal", 64'(br.Y_canal), 64'(q_r[0].c));
        if (br.Y_ready) void'(q_r.pop_front());
      end
    end
  end

  initial begin
    bf.D = 40'h5544A52211;
    bf.D_valid = '1;
    bf.S = 3'd0;
    bf.Y_ready = 1'b1;
    br.D = 32'h44332211;
    br.D_valid = '1;
    br.S = '0;
    br.Y_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);

    // Reset with every request active.
    step();
    step();
    chk("rst_y_fixo", 64'(bf.Y), 64'h0);
    chk("rst_valid_fixo", 64'(bf.Y_valid), 64'h0);
    chk("rst_canal_fixo", 64'(bf.Y_canal), 64'h0);
    chk("rst_y_rr", 64'(br.Y), 64'h0);
    chk("rst_valid_rr", 64'(br.Y_valid), 64'h0);
    chk("rst_canal_rr", 64'(br.Y_canal), 64'h0);
    chk("rst_d_ready_rr", 64'(br.D_ready), 64'h0);
    chk("rst_d_ready_fixo", 64'(bf.D_ready), 64'h0);

    // Round-robin fairness from ptr=0.
    rst_n = 1'b1;
    bf.D_valid = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_seq_canal", 64'(br.Y_canal), 64'(k % 4));
      chk("rr_seq_valid", 64'(br.Y_valid), 64'h1);
    end

    // Skip and wrap: move ptr to 1, then requests only on 0 and 3.
    br.D_valid = 4'b0001;
    step();
    br.D_valid = 4'b1001;
    step();
    chk("rr_skip_canal", 64'(br.Y_canal), 64'h3);
    step();
    chk("rr_wrap_canal", 64'(br.Y_canal), 64'h0);

    // Backpressure: hold 3C for five cycles, then consume and reload together.
    br.D = 32'h00003C00;
    br.D_valid = 4'b0010;
    step();
    chk("bp_load", 64'(br.Y), 64'h3C);
    br.D_valid = '1;
    br.Y_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_y", 64'(br.Y), 64'h3C);
      chk("bp_hold_ready", 64'(br.D_ready), 64'h0);
    end
    br.Y_ready = 1'b1;
    step();
    chk("bp_nobubble_valid", 64'(br.Y_valid), 64'h1);
    chk("bp_nobubble_canal", 64'(br.Y_canal), 64'h2);

    // Fixed select, then an out-of-range select.
    br.D_valid = '0;
    bf.D = 40'h5544A52211;
    bf.D_valid = '1;
    bf.S = 3'd2;
    step();
    chk("fixo_y", 64'(bf.Y), 64'hA5);
    chk("fixo_canal", 64'(bf.Y_canal), 64'h2);
    bf.S = 3'd5;
    #1;
    chk("fixo_s_fora", 64'(bf.D_ready), 64'h0);
    step();
    bf.D_valid = '0;

    // Reset while a word is held under backpressure.
    br.D = 32'h44332211;
    br.D_valid = 4'b0010;
    step();
    br.Y_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    br.D_valid = '0;
    br.Y_ready = 1'b1;
    chk("rst_mid_valid", 64'(br.Y_valid), 64'h0);
    chk("rst_mid_y", 64'(br.Y), 64'h0);
    chk("rst_mid_canal", 64'(br.Y_canal), 64'h0);
    br.D_valid = '1;
    step();
    chk("rst_mid_ptr", 64'(br.Y_canal), 64'h0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bf.D = 40'({$urandom(), $urandom()});
      bf.D_valid = 5'($urandom());
      bf.S = 3'($urandom());
      bf.Y_ready = ($urandom_range(0, 3) != 0);
      br.D = $urandom();
      br.D_valid = 4'($urandom());
      br.Y_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    rst_n = 1'b1;
    bf.D_valid = '0;
    br.D_valid = '0;
    bf.Y_ready = 1'b1;
    br.Y_ready = 1'b1;
    step();
    step();
    chk("fila_fixo_vazia", 64'(q_f.size()), 64'h0);
    chk("fila_rr_vazia", 64'(q_r.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
